// File: rtl/ccsds_test_pkg.sv
// Shared types and constants for the compressor stream checkers.
// State encoding, throttle modes and LFSR constants.
package ccsds_test_pkg;

  typedef enum logic [1:0] {
    SKIPPING,
    RUN,
    DONE,
    TIMEOUT
  } state_t;

  localparam int unsigned THR_ALWAYS   = 0;
  localparam int unsigned THR_LFSR     = 1;
  localparam int unsigned THR_PERIODIC = 2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_throttle_gen.sv
// Ready gate generator: always, LFSR pseudo-random or periodic.
// Shared by the comparator and the golden reader.
module axis_throttle_gen
  import ccsds_test_pkg::*;
#(
  parameter int unsigned MODE   = THR_ALWAYS,
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic thr_ok
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [15:0]   lfsr;
  logic [PW-1:0] per_cnt;
  logic          fb;

  assign fb = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= LFSR_SEED;
      per_cnt <= '0;
    end else begin
      lfsr <= {lfsr[14:0], fb};
      if (per_cnt == PW'(PERIOD - 1))
        per_cnt <= '0;
      else
        per_cnt <= per_cnt + 1'b1;
    end
  end

  always_comb begin
    thr_ok = 1'b1;
    case (MODE)
      THR_LFSR:     thr_ok = |lfsr[1:0];
      THR_PERIODIC: thr_ok = (per_cnt == '0);
      default:      thr_ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/axis_stream_comparator.sv
// Multi-lane AXI-stream checker: DUT beats against a golden stream,
// with skip, throttling, mismatch statistics, watchdog and overrun.
module axis_stream_comparator
  import ccsds_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned LANES           = 1,
  parameter logic [LANES-1:0] LANE_ENABLE = '1,
  parameter int unsigned SKIP            = 0,
  parameter int unsigned EXPECTED_BEATS  = 1024,
  parameter int unsigned THROTTLE_MODE   = THR_ALWAYS,
  parameter int unsigned THROTTLE_PERIOD = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dut_valid,
  input  logic [LANES*DATA_WIDTH-1:0] dut_data,
  output logic                        dut_ready,
  input  logic                        gold_valid,
  input  logic [LANES*DATA_WIDTH-1:0] gold_data,
  output logic                        gold_ready,
  output logic [COUNT_WIDTH-1:0]      beat_count,
  output logic [COUNT_WIDTH-1:0]      mismatch_count,
  output logic [COUNT_WIDTH-1:0]      first_err_index,
  output logic [LANES-1:0]            first_err_lanes,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic                        overrun
);

  localparam int unsigned CW = COUNT_WIDTH;
  localparam state_t ST_INIT = (SKIP > 0) ? SKIPPING : RUN;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t          state;
  state_t          state_nx;
  logic            thr_ok;
  logic [CW-1:0]   skip_cnt;
  logic [CW-1:0]   xfer_cnt;
  logic [CW-1:0]   idle_cnt;
  logic [LANES-1:0] diff_c;
  logic [LANES-1:0] diff_q;
  logic            cmp_vld;
  logic            cmp_last;
  logic            fin;
  logic            xfer_dut;
  logic            xfer_run;
  logic            any_xfer;
  logic            skip_last;
  logic            run_last;
  logic            wd_hit;
  logic            active;

  axis_throttle_gen #(
    .MODE  (THROTTLE_MODE),
    .PERIOD(THROTTLE_PERIOD)
  ) u_thr (
    .clk   (clk),
    .rst_n (rst),
    .thr_ok(thr_ok)
  );

  assign active    = (state == SKIPPING) || (state == RUN);
  assign xfer_dut  = dut_valid & dut_ready;
  assign xfer_run  = (state == RUN) & xfer_dut & gold_valid;
  assign any_xfer  = xfer_dut;
  assign skip_last = (skip_cnt == CW'(SKIP - 1));
  assign run_last  = (xfer_cnt == CW'(EXPECTED_BEATS - 1));
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && active && !any_xfer &&
                     (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    diff_c = '0;
    for (int i = 0; i < int'(LANES); i++)
      diff_c[i] = LANE_ENABLE[i] &
        (dut_data[i*DATA_WIDTH +: DATA_WIDTH] !=
         gold_data[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SKIPPING: begin
        if (wd_hit)                    state_nx = TIMEOUT;
        else if (xfer_dut && skip_last) state_nx = RUN;
      end
      RUN: begin
        if (wd_hit)                    state_nx = TIMEOUT;
        else if (xfer_run && run_last) state_nx = DONE;
      end
      default: state_nx = state;
    endcase
  end

  // In RUN each ready looks only at the other stream's valid
  always_comb begin
    dut_ready  = 1'b0;
    gold_ready = 1'b0;
    unique case (state)
      SKIPPING: dut_ready = thr_ok;
      RUN: begin
        dut_ready  = thr_ok & gold_valid;
        gold_ready = thr_ok & dut_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_cnt <= '0;
      xfer_cnt <= '0;
      idle_cnt <= '0;
      cmp_vld  <= 1'b0;
      cmp_last <= 1'b0;
      diff_q   <= '0;
    end else begin
      cmp_vld  <= xfer_run;
      cmp_last <= xfer_run & run_last;
      if (xfer_run) diff_q <= diff_c;
      if ((state == SKIPPING) && xfer_dut) skip_cnt <= inc(skip_cnt);
      if (xfer_run) xfer_cnt <= inc(xfer_cnt);
      if (active) idle_cnt <= any_xfer ? '0 : inc(idle_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count      <= '0;
      mismatch_count  <= '0;
      first_err_index <= '0;
      first_err_lanes <= '0;
      fin             <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      if (cmp_vld) begin
        beat_count <= inc(beat_count);
        if (|diff_q) begin
          mismatch_count <= inc(mismatch_count);
          if (mismatch_count == '0) begin
            first_err_index <= beat_count;
            first_err_lanes <= diff_q;
          end
        end
      end
      fin     <= cmp_vld & cmp_last;
      done    <= done | fin;
      timeout <= timeout | wd_hit;
      overrun <= overrun | ((state == DONE) & dut_valid);
    end
  end

  assign pass = done & (mismatch_count == '0) & ~overrun;

endmodule

// File: tb/tb_axis_stream_comparator.sv
// Scoreboard bench for axis_stream_comparator over four
// parameter sets: plain, lane-masked, skip and periodic throttle.
module tb_axis_stream_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dv [4];
  logic        gv [4];
  logic [19:0] dd [4];
  logic [19:0] gd [4];
  logic        dr [4];
  logic        gr [4];
  logic [31:0] bc [4];
  logic [31:0] mc [4];
  logic [31:0] fei[4];
  logic [1:0]  fel[4];
  logic        dn [4];
  logic        ps [4];
  logic        to [4];
  logic        ov [4];

  logic [19:0] dq[$];
  logic [19:0] gq[$];
  logic [1:0]  sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc, first_done, last_fire, prev_fire, unpaired, to_cyc;

  always #5 clk = ~clk;

  axis_stream_comparator #(
    .DATA_WIDTH(10), .LANES(2), .LANE_ENABLE(2'b11), .SKIP(0),
    .EXPECTED_BEATS(8), .THROTTLE_MODE(0), .THROTTLE_PERIOD(4),
    .TIMEOUT_CYCLES(16), .COUNT_WIDTH(32)
  ) u0 (
    .clk(clk), .rst(rst),
    .dut_valid(dv[0]), .dut_data(dd[0]), .dut_ready(dr[0]),
    .gold_valid(gv[0]), .gold_data(gd[0]), .gold_ready(gr[0]),
    .beat_count(bc[0]), .mismatch_count(mc[0]),
    .first_err_index(fei[0]), .first_err_lanes(fel[0]),
    .done(dn[0]), .pass(ps[0]), .timeout(to[0]), .overrun(ov[0])
  );

  axis_stream_comparator #(
    .DATA_WIDTH(10), .LANES(2), .LANE_ENABLE(2'b01), .SKIP(0),
    .EXPECTED_BEATS(8), .THROTTLE_MODE(0), .THROTTLE_PERIOD(4),
    .TIMEOUT_CYCLES(0), .COUNT_WIDTH(32)
  ) u1 (
    .clk(clk), .rst(rst),
    .dut_valid(dv[1]), .dut_data(dd[1]), .dut_ready(dr[1]),
    .gold_valid(gv[1]), .gold_data(gd[1]), .gold_ready(gr[1]),
    .beat_count(bc[1]), .mismatch_count(mc[1]),
    .first_err_index(fei[1]), .first_err_lanes(fel[1]),
    .done(dn[1]), .pass(ps[1]), .timeout(to[1]), .overrun(ov[1])
  );

  axis_stream_comparator #(
    .DATA_WIDTH(10), .LANES(2), .LANE_ENABLE(2'b11), .SKIP(3),
    .EXPECTED_BEATS(8), .THROTTLE_MODE(0), .THROTTLE_PERIOD(4),
    .TIMEOUT_CYCLES(0), .COUNT_WIDTH(32)
  ) u2 (
    .clk(clk), .rst(rst),
    .dut_valid(dv[2]), .dut_data(dd[2]), .dut_ready(dr[2]),
    .gold_valid(gv[2]), .gold_data(gd[2]), .gold_ready(gr[2]),
    .beat_count(bc[2]), .mismatch_count(mc[2]),
    .first_err_index(fei[2]), .first_err_lanes(fel[2]),
    .done(dn[2]), .pass(ps[2]), .timeout(to[2]), .overrun(ov[2])
  );

  axis_stream_comparator #(
    .DATA_WIDTH(10), .LANES(2), .LANE_ENABLE(2'b11), .SKIP(0),
    .EXPECTED_BEATS(8), .THROTTLE_MODE(2), .THROTTLE_PERIOD(4),
    .TIMEOUT_CYCLES(0), .COUNT_WIDTH(32)
  ) u3 (
    .clk(clk), .rst(rst),
    .dut_valid(dv[3]), .dut_data(dd[3]), .dut_ready(dr[3]),
    .gold_valid(gv[3]), .gold_data(gd[3]), .gold_ready(gr[3]),
    .beat_count(bc[3]), .mismatch_count(mc[3]),
    .first_err_index(fei[3]), .first_err_lanes(fel[3]),
    .done(dn[3]), .pass(ps[3]), .timeout(to[3]), .overrun(ov[3])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] lane_diff(input logic [19:0] a,
                                           input logic [19:0] b);
    return {a[19:10] != b[19:10], a[9:0] != b[9:0]};
  endfunction

  task automatic do_reset;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0;
      gv[k] = 1'b0;
      dd[k] = '0;
      gd[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill(input int junk, input int nd);
    dq.delete();
    gq.delete();
    for (int j = 0; j < junk; j++) dq.push_back(20'h55555);
    for (int b = 0; b < nd; b++)
      dq.push_back({10'(2*b+1), 10'(2*b)});
    for (int b = 0; b < 8; b++)
      gq.push_back({10'(2*b+1), 10'(2*b)});
  endtask

  task automatic run(input int k, input logic [1:0] le,
                     input int budget);
    int di, gi;
    logic df, gf;
    logic [31:0] pbc, pmc;
    logic [1:0] e;
    di = 0; gi = 0; cyc = 0; first_done = 0; last_fire = 0;
    prev_fire = 0; unpaired = 0; to_cyc = 0;
    sb.delete();
    @(posedge clk); #1;
    pbc = bc[k];
    pmc = mc[k];
    while (cyc < budget) begin
      dv[k] = (di < dq.size());
      if (dv[k]) dd[k] = dq[di];
      gv[k] = (gi < gq.size());
      if (gv[k]) gd[k] = gq[gi];
      @(negedge clk);
      df = dv[k] & dr[k];
      gf = gv[k] & gr[k];
      @(posedge clk); #1;
      cyc++;
      if (df && gf) begin
        sb.push_back(le & lane_diff(dd[k], gd[k]));
        if (k == 3 && prev_fire != 0)
          check("period_gap", cyc - prev_fire, 4);
        prev_fire = cyc;
        last_fire = cyc;
      end else if (df || gf) begin
        unpaired++;
      end
      if (df) di++;
      if (gf) gi++;
      if (bc[k] != pbc) begin
        check("sb_has_beat", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("mm_step", mc[k] - pmc, 32'(e != 2'b00));
        end
        pbc = bc[k];
        pmc = mc[k];
      end
      if (dn[k] && first_done == 0) first_done = cyc;
      if (to[k] && to_cyc == 0) to_cyc = cyc;
      if (to_cyc != 0) break;
      if (di == dq.size() && gi == gq.size() && sb.size() == 0 && dn[k])
        break;
    end
    check("in_budget", 32'(cyc < budget), 1);
    dv[k] = 1'b0;
    gv[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0; gv[k] = 1'b0; dd[k] = '0; gd[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_beat", bc[0], 0);
    check("rst_mm", mc[0], 0);
    check("rst_fei", fei[0], 0);
    check("rst_fel", 32'(fel[0]), 0);
    check("rst_done", 32'(dn[0]), 0);
    check("rst_pass", 32'(ps[0]), 0);
    check("rst_to", 32'(to[0]), 0);
    check("rst_ov", 32'(ov[0]), 0);

    // identical streams, then one surplus DUT beat
    do_reset();
    fill(0, 8);
    run(0, 2'b11, 60);
    check("t1_done_cyc", first_done, 10);
    check("t1_beats", bc[0], 8);
    check("t1_mm", mc[0], 0);
    check("t1_pass", 32'(ps[0]), 1);
    dv[0] = 1'b1;
    gv[0] = 1'b1;
    dd[0] = 20'h12345;
    @(negedge clk);
    check("t1_dready", 32'(dr[0]), 0);
    check("t1_gready", 32'(gr[0]), 0);
    @(posedge clk); #1;
    dv[0] = 1'b0;
    gv[0] = 1'b0;
    check("ovr_flag", 32'(ov[0]), 1);
    check("ovr_pass", 32'(ps[0]), 0);
    check("ovr_done", 32'(dn[0]), 1);
    @(negedge clk);
    check("ovr_dready", 32'(dr[0]), 0);

    // lane 1 corrupted on beat 3
    do_reset();
    fill(0, 8);
    dq[3] = {10'h3FF, dq[3][9:0]};
    run(0, 2'b11, 60);
    check("t2_mm", mc[0], 1);
    check("t2_fei", fei[0], 3);
    check("t2_fel", 32'(fel[0]), 2);
    check("t2_pass", 32'(ps[0]), 0);
    check("t2_done", 32'(dn[0]), 1);

    do_reset();
    fill(0, 8);
    dq[3] = {10'h3FF, dq[3][9:0]};
    run(1, 2'b01, 60);
    check("t2m_mm", mc[1], 0);
    check("t2m_pass", 32'(ps[1]), 1);

    // three junk beats skipped
    do_reset();
    fill(3, 8);
    run(2, 2'b11, 80);
    check("t3_skipped", unpaired, 3);
    check("t3_beats", bc[2], 8);
    check("t3_pass", 32'(ps[2]), 1);

    // periodic throttle
    do_reset();
    fill(0, 8);
    run(3, 2'b11, 80);
    check("t4_last_rng", 32'(last_fire >= 29 && last_fire <= 32), 1);
    check("t4_beats", bc[3], 8);
    check("t4_pass", 32'(ps[3]), 1);

    // DUT stalls after five beats
    do_reset();
    fill(0, 5);
    run(0, 2'b11, 60);
    check("t5_to_gap", to_cyc - last_fire, 16);
    check("t5_to", 32'(to[0]), 1);
    check("t5_done", 32'(dn[0]), 0);
    check("t5_beats", bc[0], 5);
    dv[0] = 1'b1;
    gv[0] = 1'b1;
    #1;
    check("t5_dready", 32'(dr[0]), 0);
    check("t5_gready", 32'(gr[0]), 0);
    dv[0] = 1'b0;
    gv[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("t5r_beats", bc[0], 0);
    check("t5r_to", 32'(to[0]), 0);
    check("t5r_done", 32'(dn[0]), 0);
    check("t5r_pass", 32'(ps[0]), 0);
    check("t5r_ov", 32'(ov[0]), 0);
    repeat (2) @(posedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
